pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use hazards and inserts a bubble.
- Flushes IF/ID on a taken branch.
- Freezes the whole pipeline while the MEM-stage data-memory access completes a req/ack handshake.
- Keeps a stall-cycle performance counter and a sticky timeout error.

Parameters:
TIMEOUT, 255, max cycles spent in WAIT before abandoning the access (1..255, 8-bit counter).
CNT_W, 16, width of the stall-cycle counter.

Ports:
Clock_i  input  1  pipeline clock, rising edge.
Reset_n_i  input  1  asynchronous active-low reset.
id_rs_i  input  5  rs field of instruction in ID.
id_rt_i  input  5  rt field of instruction in ID.
ex_memread_i  input  1  instruction in EX is a load.
ex_rd_i  input  5  destination register of instruction in EX.
id_branch_taken_i  input  1  branch in ID resolved taken.
mem_access_i  input  1  instruction in MEM performs a load or store.
dmem_ack_i  input  1  data memory completes the requested access.
pc_write_o  output  1  PC update enable.
ifid_write_o  output  1  IF/ID write enable.
ifid_flush_o  output  1  IF/ID synchronous clear to NOP.
idex_bubble_o  output  1  zero control fields entering ID/EX.
pipe_freeze_o  output  1  hold ID/EX, EX/MEM, MEM/WB contents.
dmem_req_o  output  1  data-memory request.
timeout_err_o  output  1  sticky; set when an access times out.
stall_cnt_o  output  CNT_W  saturating count of cycles with pc_write_o=0.

Behaviour:
- FSM states RUN, WAIT, DONE. State, timeout counter, timeout_err_o and stall_cnt_o are registered; all other outputs are combinational from state and inputs.
- Reset (Reset_n_i=0, asynchronous): state=RUN, wait counter=0, timeout_err_o=0, stall_cnt_o=0. Outputs then follow the RUN equations. Reset mid-WAIT drops dmem_req_o immediately.
- RUN, mem_access_i=1: freeze this cycle and go to WAIT.
  - pipe_freeze_o=1, pc_write_o=0, ifid_write_o=0.
  - idex_bubble_o=0, ifid_flush_o=0.
- RUN, mem_access_i=0: hazard logic applies.
  - load_use = ex_memread_i && ex_rd_i!=0 && (ex_rd_i==id_rs_i || ex_rd_i==id_rt_i).
  - load_use=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. Stall beats flush; the branch re-resolves next cycle.
  - Otherwise: pc_write_o=1, ifid_write_o=1, idex_bubble_o=0, ifid_flush_o=id_branch_taken_i.
- WAIT:
  - Outputs: dmem_req_o=1; freeze outputs as in RUN with mem_access_i=1.
  - Wait counter increments each WAIT cycle.
  - dmem_ack_i=1 → DONE; ack may arrive in the first WAIT cycle.
  - Counter reaches TIMEOUT with no ack → timeout_err_o set (sticky until reset), then DONE.
  - Ack in the same cycle as the counter hits TIMEOUT: the ack wins and no error is set.
  - dmem_ack_i outside WAIT is ignored.
- DONE:
  - dmem_req_o=0, pipe_freeze_o=0. Hazard equations apply exactly as in RUN with mem_access_i=0. The pipeline advances one cycle and MEM/WB captures the result.
  - mem_access_i is ignored this cycle so the same instruction is not re-requested.
  - Clear wait counter; go to RUN.
- Minimum memory-op cost is 2 extra cycles (RUN-detect + WAIT).
- Back-to-back memory ops: each one re-enters WAIT from RUN.
- dmem_req_o is 0 in RUN and DONE.
- stall_cnt_o increments by 1 on every clock edge where pc_write_o=0, and saturates at all-ones.

Test Plan:
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs_i=5, mem_access_i=0 → pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for that cycle; stall_cnt_o 0→1. Same stimulus with ex_rd_i=0 → no stall.
- Branch: id_branch_taken_i=1, no hazard → ifid_flush_o=1, pc_write_o=1. Add load-use in the same cycle → ifid_flush_o=0, idex_bubble_o=1.
- Memory access: mem_access_i=1 with ack 3 cycles after req → RUN→WAIT(3)→DONE→RUN.
  - pipe_freeze_o=1 for 4 cycles; dmem_req_o=1 for exactly 3 cycles; stall_cnt_o +=4.
- Ack in the first WAIT cycle → dmem_req_o high 1 cycle, freeze 2 cycles. In DONE with mem_access_i still 1 → no new req.
- Timeout with TIMEOUT=4 and no ack → dmem_req_o high 4 cycles, timeout_err_o=1 and held. Ack at count 4 → timeout_err_o stays 0.
- Reset: assert Reset_n_i=0 mid-WAIT → dmem_req_o=0 asynchronously; stall_cnt_o=0, timeout_err_o=0, state RUN after release. Saturation: preload 2^CNT_W−1 stall cycles → stall_cnt_o holds at all-ones.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for a 5-stage pipeline: load-use bubbles, taken-branch
// flushes and whole-pipe freeze around a req/ack data-memory access.
module pipeline_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             Clock_i,
   input  logic             Reset_n_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             id_branch_taken_i,
   input  logic             mem_access_i,
   input  logic             dmem_ack_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_freeze_o,
   output logic             dmem_req_o,
   output logic             timeout_err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
   localparam logic [CNT_W-1:0] STALL_MAX = '1;

   state_t           r_state;
   logic [7:0]       r_wait_cnt;
   logic             r_timeout_err;
   logic [CNT_W-1:0] r_stall_cnt;

   logic       w_load_use;
   logic       w_hold;
   logic [7:0] w_wait_inc;

   assign w_load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                       ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));

   // DONE deliberately ignores mem_access_i so the finishing op is not re-requested.
   assign w_hold     = (r_state == ST_WAIT) || ((r_state == ST_RUN) && mem_access_i);
   assign w_wait_inc = r_wait_cnt + 8'd1;

   // NOTE: every output gets a default before the conditional overrides, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
      dmem_req_o    = (r_state == ST_WAIT);
      if (w_hold) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         pipe_freeze_o = 1'b1;
      end else if (w_load_use) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else begin
         ifid_flush_o  = id_branch_taken_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clock_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= 8'd0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (mem_access_i) r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               r_wait_cnt <= w_wait_inc;
               if (dmem_ack_i) begin
                  r_state <= ST_DONE;
               end else if (w_wait_inc == TIMEOUT_C) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_wait_cnt <= 8'd0;
               r_state    <= ST_RUN;
            end
            default: begin
               r_wait_cnt <= 8'd0;
               r_state    <= ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge Clock_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         r_stall_cnt <= '0;
      end else if (!pc_write_o && (r_stall_cnt != STALL_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign timeout_err_o = r_timeout_err;
   assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a transaction-level model of the scheduler.
module tb_pipeline_ctrl;

   localparam int unsigned TIMEOUT   = 4;
   localparam int unsigned CNT_W     = 8;
   localparam int          STALL_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             ex_memread;
   logic [4:0]       ex_rd;
   logic             br_taken;
   logic             mem_access;
   logic             dmem_ack;
   logic             pc_write_o;
   logic             ifid_write_o;
   logic             ifid_flush_o;
   logic             idex_bubble_o;
   logic             pipe_freeze_o;
   logic             dmem_req_o;
   logic             timeout_err_o;
   logic [CNT_W-1:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;

   pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .Clock_i          (clk),
      .Reset_n_i        (rst_n),
      .id_rs_i          (id_rs),
      .id_rt_i          (id_rt),
      .ex_memread_i     (ex_memread),
      .ex_rd_i          (ex_rd),
      .id_branch_taken_i(br_taken),
      .mem_access_i     (mem_access),
      .dmem_ack_i       (dmem_ack),
      .pc_write_o       (pc_write_o),
      .ifid_write_o     (ifid_write_o),
      .ifid_flush_o     (ifid_flush_o),
      .idex_bubble_o    (idex_bubble_o),
      .pipe_freeze_o    (pipe_freeze_o),
      .dmem_req_o       (dmem_req_o),
      .timeout_err_o    (timeout_err_o),
      .stall_cnt_o      (stall_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Transaction-level model: an access is either outstanding (bus request up)
   // or just finished (one cycle where the pipe advances and new ops are ignored).
   bit m_busy;
   int m_waited;
   bit m_just_done;
   bit m_err;
   int m_stalls;

   logic exp_pc, exp_ifw, exp_flush, exp_bub, exp_frz, exp_req;
   logic obs_pc, obs_ifw, obs_flush, obs_bub, obs_frz, obs_req;

   task automatic model_reset();
      m_busy      = 1'b0;
      m_waited    = 0;
      m_just_done = 1'b0;
      m_err       = 1'b0;
      m_stalls    = 0;
   endtask

   task automatic model_expect();
      bit hold;
      bit lu;
      hold = m_busy || (!m_just_done && mem_access);
      lu   = ex_memread && (ex_rd != 0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
      exp_pc    = !hold && !lu;
      exp_ifw   = !hold && !lu;
      exp_bub   = !hold && lu;
      exp_flush = !hold && !lu && br_taken;
      exp_frz   = hold;
      exp_req   = m_busy;
   endtask

   task automatic model_advance();
      if (!exp_pc) m_stalls = (m_stalls < STALL_MAX) ? m_stalls + 1 : STALL_MAX;
      if (m_busy) begin
         m_waited++;
         if (dmem_ack || m_waited == int'(TIMEOUT)) begin
            if (!dmem_ack) m_err = 1'b1;
            m_busy      = 1'b0;
            m_just_done = 1'b1;
         end
      end else if (m_just_done) begin
         m_just_done = 1'b0;
      end else if (mem_access) begin
         m_busy   = 1'b1;
         m_waited = 0;
      end
   endtask

   // One clock cycle: sample combinational outputs at the falling edge, then
   // advance the model across the rising edge and return 1 time unit after it.
   task automatic tick();
      @(negedge clk);
      model_expect();
      obs_pc    = pc_write_o;
      obs_ifw   = ifid_write_o;
      obs_flush = ifid_flush_o;
      obs_bub   = idex_bubble_o;
      obs_frz   = pipe_freeze_o;
      obs_req   = dmem_req_o;
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs      = 5'd0;
      id_rt      = 5'd0;
      ex_memread = 1'b0;
      ex_rd      = 5'd0;
      br_taken   = 1'b0;
      mem_access = 1'b0;
      dmem_ack   = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (stall_cnt_o !== '0 || timeout_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: stall_cnt=%0d err=%b, required 0/0", stall_cnt_o, timeout_err_o);
      end
      tick();
      checks++;
      if ({obs_pc, obs_ifw, obs_frz, obs_req} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_run_outputs: pc/ifw/frz/req=%b, required 1100",
                  {obs_pc, obs_ifw, obs_frz, obs_req});
      end
   endtask

   task automatic test_load_use();
      apply_reset();
      ex_memread = 1'b1;
      ex_rd      = 5'd5;
      id_rs      = 5'd5;
      id_rt      = 5'd9;
      tick();
      checks++;
      if ({obs_pc, obs_ifw, obs_bub} !== 3'b001) begin
         errors++;
         $display("FAIL load_use_stall: pc/ifw/bubble=%b, required 001", {obs_pc, obs_ifw, obs_bub});
      end
      checks++;
      if (stall_cnt_o !== 8'd1) begin
         errors++;
         $display("FAIL load_use_count: stall_cnt=%0d, required 1", stall_cnt_o);
      end
      ex_rd = 5'd0;
      id_rs = 5'd0;
      tick();
      checks++;
      if ({obs_pc, obs_ifw, obs_bub} !== 3'b110 || stall_cnt_o !== 8'd1) begin
         errors++;
         $display("FAIL load_use_r0: pc/ifw/bubble=%b stall_cnt=%0d, required 110 and 1",
                  {obs_pc, obs_ifw, obs_bub}, stall_cnt_o);
      end
   endtask

   task automatic test_branch();
      apply_reset();
      br_taken = 1'b1;
      tick();
      checks++;
      if ({obs_flush, obs_pc, obs_bub} !== 3'b110) begin
         errors++;
         $display("FAIL branch_flush: flush/pc/bubble=%b, required 110", {obs_flush, obs_pc, obs_bub});
      end
      ex_memread = 1'b1;
      ex_rd      = 5'd7;
      id_rt      = 5'd7;
      tick();
      checks++;
      if ({obs_flush, obs_pc, obs_bub} !== 3'b001) begin
         errors++;
         $display("FAIL branch_vs_stall: flush/pc/bubble=%b, required 001", {obs_flush, obs_pc, obs_bub});
      end
   endtask

   // ack_after = WAIT cycle on which ack is raised; 0 means never (timeout).
   task automatic test_mem_access(input int ack_after);
      int req_cycles;
      int frz_cycles;
      int exp_req_n;
      apply_reset();
      req_cycles = 0;
      frz_cycles = 0;
      for (int k = 0; k < int'(TIMEOUT) + 5; k++) begin
         mem_access = (k == 0) || m_busy || m_just_done;
         dmem_ack   = m_busy && (ack_after != 0) && (m_waited + 1 == ack_after);
         if (m_just_done) begin
            tick();
            checks++;
            if (obs_req !== 1'b0 || obs_frz !== 1'b0 || obs_pc !== 1'b1) begin
               errors++;
               $display("FAIL done_ignores_access: req=%b frz=%b pc=%b, required 0 0 1",
                        obs_req, obs_frz, obs_pc);
            end
         end else begin
            tick();
         end
         req_cycles += int'(obs_req);
         frz_cycles += int'(obs_frz);
      end
      exp_req_n = (ack_after == 0) ? int'(TIMEOUT) : ack_after;
      checks++;
      if (req_cycles != exp_req_n || frz_cycles != exp_req_n + 1) begin
         errors++;
         $display("FAIL mem_access_%0d_len: req=%0d frz=%0d, required %0d %0d",
                  ack_after, req_cycles, frz_cycles, exp_req_n, exp_req_n + 1);
      end
      checks++;
      if (stall_cnt_o !== CNT_W'(exp_req_n + 1)) begin
         errors++;
         $display("FAIL mem_access_%0d_stalls: stall_cnt=%0d, required %0d",
                  ack_after, stall_cnt_o, exp_req_n + 1);
      end
      checks++;
      if (timeout_err_o !== (ack_after == 0)) begin
         errors++;
         $display("FAIL mem_access_%0d_err: err=%b, required %b", ack_after, timeout_err_o, ack_after == 0);
      end
   endtask

   // Runs right after a timeout, so the sticky error is also shown to clear.
   task automatic test_reset_mid_wait();
      idle_inputs();
      tick();
      checks++;
      if (timeout_err_o !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: err=%b, required 1", timeout_err_o);
      end
      mem_access = 1'b1;
      tick();
      tick();
      checks++;
      if (dmem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL wait_req_before_reset: req=%b, required 1", dmem_req_o);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (dmem_req_o !== 1'b0 || stall_cnt_o !== '0 || timeout_err_o !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: req=%b stall_cnt=%0d err=%b, required 0 0 0",
                  dmem_req_o, stall_cnt_o, timeout_err_o);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mem_access = 1'b0;
      tick();
      mem_access = 1'b1;
      tick();
      checks++;
      if (obs_req !== 1'b0 || obs_frz !== 1'b1) begin
         errors++;
         $display("FAIL run_after_reset: req=%b frz=%b, required 0 1", obs_req, obs_frz);
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      ex_memread = 1'b1;
      ex_rd      = 5'd3;
      id_rs      = 5'd3;
      for (int k = 0; k < STALL_MAX + 6; k++) tick();
      checks++;
      if (stall_cnt_o !== CNT_W'(STALL_MAX)) begin
         errors++;
         $display("FAIL stall_saturate: stall_cnt=%0d, required %0d", stall_cnt_o, STALL_MAX);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int k = 0; k < 2000; k++) begin
         id_rs      = 5'($urandom_range(0, 3));
         id_rt      = 5'($urandom_range(0, 3));
         ex_rd      = 5'($urandom_range(0, 3));
         ex_memread = ($urandom_range(0, 2) == 0);
         br_taken   = ($urandom_range(0, 3) == 0);
         mem_access = ($urandom_range(0, 4) == 0);
         dmem_ack   = ($urandom_range(0, 3) == 0);
         tick();
         checks++;
         if ({obs_pc, obs_ifw, obs_flush, obs_bub, obs_frz, obs_req} !==
             {exp_pc, exp_ifw, exp_flush, exp_bub, exp_frz, exp_req}) begin
            errors++;
            $display("FAIL random_outputs cycle %0d: pc/ifw/flush/bub/frz/req=%b, required %b", k,
                     {obs_pc, obs_ifw, obs_flush, obs_bub, obs_frz, obs_req},
                     {exp_pc, exp_ifw, exp_flush, exp_bub, exp_frz, exp_req});
         end
         checks++;
         if (stall_cnt_o !== CNT_W'(m_stalls) || timeout_err_o !== m_err) begin
            errors++;
            $display("FAIL random_regs cycle %0d: stall_cnt=%0d err=%b, required %0d %b", k,
                     stall_cnt_o, timeout_err_o, m_stalls, m_err);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1;
      idle_inputs();
      model_reset();
      #2;
      test_reset();
      test_load_use();
      test_branch();
      test_mem_access(3);
      test_mem_access(1);
      test_mem_access(int'(TIMEOUT));
      test_mem_access(0);
      test_reset_mid_wait();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
